// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: generates the PS/2 clock and shifts out
// 11-bit frames (start, 8 data LSB first, odd parity, stop) to the host,
// retrying automatically when the host inhibits the bus mid-frame.
module ps2_device_tx #(
  parameter int unsigned HALFBIT_CYCLES = 1120,
  parameter int unsigned BUSIDLE_CYCLES = 1400,
  parameter int unsigned GAP_CYCLES     = 1400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       dataload,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       host_rts
);

  localparam int unsigned MAX_A = (HALFBIT_CYCLES > BUSIDLE_CYCLES) ? HALFBIT_CYCLES : BUSIDLE_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int unsigned CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALFBIT_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(BUSIDLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WAITBUS, HIGH, LOW, ABORT, GAP} state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [3:0]    idx_q, idx_n;
  logic [7:0]    byte_q, byte_n;
  logic          clk_oe_q, clk_oe_n;
  logic          data_oe_q, data_oe_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic          aborted_q, aborted_n;
  logic          clk_meta, clk_s;
  logic          dat_meta, dat_s;

  // Frame bit i: 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
  function automatic logic frame_bit(input logic [3:0] i, input logic [7:0] b);
    logic r;
    if (i == 4'd0)      r = 1'b0;
    else if (i <= 4'd8) r = b[3'(i - 4'd1)];
    else if (i == 4'd9) r = ~^b;
    else                r = 1'b1;
    return r;
  endfunction

  // State, counters and registered pad drives; sync flops for the pads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      byte_q    <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      clk_meta  <= 1'b0;
      clk_s     <= 1'b0;
      dat_meta  <= 1'b0;
      dat_s     <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      idx_q     <= idx_n;
      byte_q    <= byte_n;
      clk_oe_q  <= clk_oe_n;
      data_oe_q <= data_oe_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      aborted_q <= aborted_n;
      clk_meta  <= ps2clk_in;
      clk_s     <= clk_meta;
      dat_meta  <= ps2data_in;
      dat_s     <= dat_meta;
    end
  end

  // Next-state logic; pad drives and pulses are computed one cycle ahead
  // so every output comes straight from a flop.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    idx_n     = idx_q;
    byte_n    = byte_q;
    clk_oe_n  = clk_oe_q;
    data_oe_n = data_oe_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dataload) begin
          byte_n  = data;
          busy_n  = 1'b1;
          cnt_n   = '0;
          state_n = WAITBUS;
        end
      end
      WAITBUS: begin
        if (clk_s && dat_s) begin
          if (cnt_q == IDLE_LAST) begin
            cnt_n     = '0;
            idx_n     = '0;
            data_oe_n = ~frame_bit(4'd0, byte_q);
            state_n   = HIGH;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end else begin
          cnt_n = '0;
        end
      end
      HIGH: begin
        if (cnt_q == HALF_LAST) begin
          cnt_n = '0;
          if (!clk_s) begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            aborted_n = 1'b1;
            state_n   = ABORT;
          end else begin
            clk_oe_n = 1'b1;
            state_n  = LOW;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      LOW: begin
        if (cnt_q == HALF_LAST) begin
          cnt_n    = '0;
          clk_oe_n = 1'b0;
          if (idx_q != 4'd10) begin
            idx_n     = idx_q + 4'd1;
            data_oe_n = ~frame_bit(idx_q + 4'd1, byte_q);
            state_n   = HIGH;
          end else begin
            data_oe_n = 1'b0;
            done_n    = 1'b1;
            state_n   = GAP;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      ABORT: begin
        cnt_n   = '0;
        state_n = WAITBUS;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_n   = '0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign ps2clk_oe  = clk_oe_q;
  assign ps2data_oe = data_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign host_rts   = (state_q == IDLE) && clk_s && !dat_s;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx with a pulled-up open-drain host model.
module tb_ps2_device_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = '0;
  logic       dataload = 1'b0;
  logic       host_clk_low = 1'b0;
  logic       host_data_low = 1'b0;
  logic       ps2clk_in, ps2data_in;
  logic       ps2clk_oe, ps2data_oe, busy, done, aborted, host_rts;

  int n_cmp = 0;
  int n_err = 0;

  assign ps2clk_in  = ~(ps2clk_oe | host_clk_low);
  assign ps2data_in = ~(ps2data_oe | host_data_low);

  ps2_device_tx #(
    .HALFBIT_CYCLES(4),
    .BUSIDLE_CYCLES(6),
    .GAP_CYCLES(6)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .dataload(dataload),
    .ps2clk_in(ps2clk_in), .ps2data_in(ps2data_in),
    .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe),
    .busy(busy), .done(done), .aborted(aborted), .host_rts(host_rts)
  );

  always #5 clk = ~clk;

  // Host-side monitor: data sampled on each device-driven clock falling edge.
  logic cap_mem [0:1023];
  int   cap_total = 0;
  int   done_total = 0;
  int   abort_total = 0;
  int   both_total = 0;
  logic prev_oe = 1'b0;

  always @(negedge clk) begin
    if (ps2clk_oe && !prev_oe && cap_total < 1024) begin
      cap_mem[cap_total] <= ps2data_in;
      cap_total <= cap_total + 1;
    end
    prev_oe <= ps2clk_oe;
    if (done) done_total <= done_total + 1;
    if (aborted) abort_total <= abort_total + 1;
    if (done && aborted) both_total <= both_total + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    data = d;
    dataload = 1'b1;
    tick();
    dataload = 1'b0;
  endtask

  task automatic wait_start(output int n, output bit ok);
    ok = 1'b0; n = 0;
    for (int i = 0; i < 400; i++) begin
      tick(); n++;
      if (ps2data_oe) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(output int n, output bit ok);
    ok = 1'b0; n = 0;
    for (int i = 0; i < 400; i++) begin
      tick(); n++;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output int n, output bit ok);
    ok = 1'b0; n = 0;
    for (int i = 0; i < 100; i++) begin
      tick(); n++;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic get_frame(input int base, output logic [10:0] f);
    for (int i = 0; i < 11; i++) f[i] = cap_mem[base + i];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({ps2clk_oe, ps2data_oe, busy, done, aborted, host_rts} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, expected 000000",
               {ps2clk_oe, ps2data_oe, busy, done, aborted, host_rts});
    end
    rst = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_basic_frame();
    int n, base, d0; bit ok; logic [10:0] f;
    d0 = done_total;
    load(8'h1C);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b, expected 1", busy); end
    wait_start(n, ok);
    n_cmp++;
    if (!ok || n != 6) begin n_err++; $display("FAIL basic_start_latency: got %0d (ok=%0d), expected 6", n, ok); end
    base = cap_total;
    wait_done(n, ok);
    n_cmp++;
    if (!ok || n != 88) begin n_err++; $display("FAIL basic_frame_time: got %0d (ok=%0d), expected 88", n, ok); end
    wait_idle(n, ok);
    n_cmp++;
    if (!ok || n != 6) begin n_err++; $display("FAIL basic_gap: got %0d (ok=%0d), expected 6", n, ok); end
    get_frame(base, f);
    n_cmp++;
    if (cap_total - base != 11 || f !== 11'h438) begin
      n_err++; $display("FAIL basic_frame: got %03h (%0d bits), expected 438 (11 bits)", f, cap_total - base);
    end
    n_cmp++;
    if (done_total - d0 != 1) begin n_err++; $display("FAIL basic_done_count: got %0d, expected 1", done_total - d0); end
  endtask

  task automatic test_parity();
    logic [7:0]  dv [3] = '{8'h00, 8'hFF, 8'h01};
    logic [10:0] ev [3] = '{11'h600, 11'h7FE, 11'h402};
    int n, base; bit ok; logic [10:0] f;
    for (int k = 0; k < 3; k++) begin
      load(dv[k]);
      wait_start(n, ok);
      base = cap_total;
      wait_done(n, ok);
      get_frame(base, f);
      n_cmp++;
      if (!ok || f !== ev[k]) begin
        n_err++; $display("FAIL parity_%02h: got %03h (ok=%0d), expected %03h", dv[k], f, ok, ev[k]);
      end
      wait_idle(n, ok);
    end
  endtask

  task automatic test_inhibit();
    int n, base, d0, a0; bit ok; logic [10:0] f;
    d0 = done_total; a0 = abort_total;
    load(8'hA5);
    wait_start(n, ok);
    base = cap_total;
    repeat (40) tick();
    host_clk_low = 1'b1;
    ok = 1'b0; n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); n++;
      if (aborted) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok || n != 4) begin n_err++; $display("FAIL inhibit_abort_latency: got %0d (ok=%0d), expected 4", n, ok); end
    n_cmp++;
    if ({ps2clk_oe, ps2data_oe, done, busy} !== 4'b0001) begin
      n_err++; $display("FAIL inhibit_release: got %b, expected 0001", {ps2clk_oe, ps2data_oe, done, busy});
    end
    n_cmp++;
    if (cap_total - base != 5) begin n_err++; $display("FAIL inhibit_bits_before: got %0d, expected 5", cap_total - base); end
    repeat (5) tick();
    host_clk_low = 1'b0;
    wait_start(n, ok);
    n_cmp++;
    if (!ok || n != 8) begin n_err++; $display("FAIL inhibit_retry_latency: got %0d (ok=%0d), expected 8", n, ok); end
    base = cap_total;
    wait_done(n, ok);
    get_frame(base, f);
    n_cmp++;
    if (!ok || f !== 11'h74A) begin n_err++; $display("FAIL inhibit_retry_frame: got %03h (ok=%0d), expected 74a", f, ok); end
    wait_idle(n, ok);
    n_cmp++;
    if (done_total - d0 != 1 || abort_total - a0 != 1) begin
      n_err++; $display("FAIL inhibit_counts: got done=%0d abort=%0d, expected done=1 abort=1", done_total - d0, abort_total - a0);
    end
  endtask

  task automatic test_host_rts();
    int n, base; bit ok; logic [10:0] f;
    host_data_low = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (host_rts !== 1'b1) begin n_err++; $display("FAIL rts_idle: got %b, expected 1", host_rts); end
    base = cap_total;
    load(8'h1C);
    n_cmp++;
    if ({busy, host_rts} !== 2'b10) begin n_err++; $display("FAIL rts_load: got %b, expected 10", {busy, host_rts}); end
    repeat (20) tick();
    n_cmp++;
    if ({ps2clk_oe, ps2data_oe} !== 2'b00 || cap_total != base) begin
      n_err++; $display("FAIL rts_wait: got oe=%b bits=%0d, expected oe=00 bits=0", {ps2clk_oe, ps2data_oe}, cap_total - base);
    end
    host_data_low = 1'b0;
    wait_start(n, ok);
    n_cmp++;
    if (!ok || n != 8) begin n_err++; $display("FAIL rts_start_latency: got %0d (ok=%0d), expected 8", n, ok); end
    base = cap_total;
    wait_done(n, ok);
    get_frame(base, f);
    n_cmp++;
    if (!ok || f !== 11'h438) begin n_err++; $display("FAIL rts_frame: got %03h (ok=%0d), expected 438", f, ok); end
    wait_idle(n, ok);
  endtask

  task automatic test_back_to_back();
    int n, base, d0, c0; bit ok; logic [10:0] f;
    d0 = done_total;
    load(8'hAA);
    wait_start(n, ok);
    base = cap_total;
    repeat (30) tick();
    load(8'h55);
    wait_done(n, ok);
    get_frame(base, f);
    n_cmp++;
    if (!ok || f !== 11'h754) begin n_err++; $display("FAIL b2b_frame: got %03h (ok=%0d), expected 754", f, ok); end
    repeat (5) tick();
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_gap_busy: got %b, expected 1", busy); end
    c0 = cap_total;
    load(8'h55);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_drop_load: got %b, expected 0", busy); end
    repeat (20) tick();
    n_cmp++;
    if (busy !== 1'b0 || cap_total != c0 || done_total - d0 != 1) begin
      n_err++; $display("FAIL b2b_no_resend: got busy=%b bits=%0d done=%0d, expected busy=0 bits=0 done=1",
                        busy, cap_total - c0, done_total - d0);
    end
    load(8'h01);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_idle_load: got %b, expected 1", busy); end
    wait_done(n, ok);
    wait_idle(n, ok);
  endtask

  task automatic test_reset_midframe();
    int n, d0, c0; bit ok;
    load(8'h00);
    wait_start(n, ok);
    repeat (29) tick();
    n_cmp++;
    if ({ps2clk_oe, ps2data_oe} !== 2'b11) begin n_err++; $display("FAIL midrst_low_phase: got %b, expected 11", {ps2clk_oe, ps2data_oe}); end
    d0 = done_total; c0 = cap_total;
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({ps2clk_oe, ps2data_oe, busy} !== 3'b000) begin
      n_err++; $display("FAIL midrst_release: got %b, expected 000", {ps2clk_oe, ps2data_oe, busy});
    end
    rst = 1'b0;
    repeat (120) tick();
    n_cmp++;
    if (done_total != d0 || cap_total != c0 || busy !== 1'b0) begin
      n_err++; $display("FAIL midrst_discard: got done=%0d bits=%0d busy=%b, expected 0 0 0", done_total - d0, cap_total - c0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_inhibit();
    test_host_rts();
    test_back_to_back();
    test_reset_midframe();
    n_cmp++;
    if (both_total != 0) begin n_err++; $display("FAIL done_and_aborted: got %0d, expected 0", both_total); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
